// File: rtl/cache_pkg.sv
// Shared types and default sizing for the cache controller slice.
package cache_pkg;

  localparam int unsigned DefWidth     = 8;
  localparam int unsigned DefWays      = 4;
  localparam int unsigned DefTotalSize = 16;
  localparam int unsigned DefRamDepth  = 256;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMemRd,
    StMemWr,
    StResp
  } state_e;

  // Way-select width; a direct-mapped cache still needs one bit to form a port.
  function automatic int unsigned way_bits(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Replacement choice for one set: lowest invalid way, else the round-robin pointer.
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int unsigned WAYS = DefWays,
  parameter int unsigned WW   = way_bits(WAYS)
) (
  input  logic [WAYS-1:0] valid_i,
  input  logic [WW-1:0]   rr_i,
  output logic [WW-1:0]   way_o
);

  always_comb begin
    way_o = rr_i;
    // Descending scan so the lowest invalid way is the last one written.
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (!valid_i[i]) way_o = WW'(i);
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Blocking set-associative write-through cache controller driving external tag/data arrays.
// Define CACHE_CTRL_WRITE_ALLOC_EN to allocate a line on a write miss.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned WAYS       = DefWays,
  parameter int unsigned TOTAL_SIZE = DefTotalSize,
  parameter int unsigned RAM_DEPTH  = DefRamDepth,
  localparam int unsigned AW   = $clog2(RAM_DEPTH),
  localparam int unsigned IW   = $clog2(TOTAL_SIZE / WAYS),
  localparam int unsigned TW   = AW - IW,
  localparam int unsigned WW   = way_bits(WAYS),
  localparam int unsigned SETS = TOTAL_SIZE / WAYS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WW-1:0]    arr_way,
  output logic [IW-1:0]    arr_index,
  output logic             tag_we,
  output logic [TW-1:0]    tag_wr,
  input  logic [TW-1:0]    tag_rd [WAYS],
  output logic             data_we,
  output logic [WIDTH-1:0] data_wr,
  input  logic [WIDTH-1:0] data_rd [WAYS]
);

`ifdef CACHE_CTRL_WRITE_ALLOC_EN
  localparam bit WriteAlloc = 1'b1;
`else
  localparam bit WriteAlloc = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q;
  logic             we_q;
  logic             miss_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WW-1:0]    rr_q    [SETS];

  logic [IW-1:0]    idx;
  logic [TW-1:0]    tag;
  logic             hit;
  logic [WW-1:0]    hit_way;
  logic [WW-1:0]    victim;
  logic             fill;

  assign idx       = addr_q[IW-1:0];
  assign tag       = addr_q[AW-1:IW];
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign tag_wr    = tag;
  assign rsp_rdata = rdata_q;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    // Descending scan: the lowest matching way wins.
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_rd[w] == tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  cache_victim_sel #(
    .WAYS (WAYS),
    .WW   (WW)
  ) u_victim_sel (
    .valid_i (valid_q[idx]),
    .rr_i    (rr_q[idx]),
    .way_o   (victim)
  );

  // Line allocation happens only in the memory-ack cycle.
  assign fill = mem_ack && ((state_q == StMemRd) ||
                            (WriteAlloc && (state_q == StMemWr) && miss_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid) state_d = StLookup;
      StLookup: begin
        if (we_q)     state_d = StMemWr;
        else if (hit) state_d = StResp;
        else          state_d = StMemRd;
      end
      StMemRd:  if (mem_ack) state_d = StResp;
      StMemWr:  if (mem_ack) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    arr_way   = '0;
    arr_index = idx;
    tag_we    = fill;
    data_we   = fill;
    data_wr   = wdata_q;
    unique case (state_q)
      StIdle: begin
        req_ready = !rst;
        arr_index = req_addr[IW-1:0];
      end
      StLookup: begin
        arr_way = hit_way;
        data_we = we_q && hit;
      end
      StMemRd: begin
        mem_req = 1'b1;
        arr_way = victim;
        data_wr = mem_rdata;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        arr_way = victim;
      end
      StResp:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      miss_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= '{default: '0};
      rr_q    <= '{default: '0};
    end else begin
      if (state_q == StIdle && req_valid) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        wdata_q <= req_wdata;
      end
      if (state_q == StLookup) begin
        miss_q <= !hit;
        if (!we_q && hit) rdata_q <= data_rd[hit_way];
      end
      if (fill) begin
        valid_q[idx][victim] <= 1'b1;
        // The pointer only advances when the victim came from it.
        if (&valid_q[idx]) rr_q[idx] <= rr_q[idx] + WW'(1);
      end
      if (state_q == StMemRd && mem_ack) rdata_q <= mem_rdata;
      if (state_q == StMemWr && mem_ack) rdata_q <= '0;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: array and memory models, response scoreboard.
module tb_cache_ctrl;

  logic       clk, rst;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0] arr_way, arr_index;
  logic       tag_we, data_we;
  logic [5:0] tag_wr;
  logic [7:0] data_wr;
  logic [5:0] tag_rd  [4];
  logic [7:0] data_rd [4];

  logic [5:0] tag_arr  [4][4];
  logic [7:0] data_arr [4][4];
  logic [7:0] ram      [256];
  logic       mem_hold;

  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  int         n_mem, n_tag, n_data, lat;
  logic       got_rsp, o_mem_we;
  logic [7:0] o_mem_addr, o_mem_wdata, o_data_val, o_rsp;
  logic [1:0] o_tag_way, o_tag_idx, o_data_way, o_data_idx;
  logic [5:0] o_tag_val;

  cache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .arr_way   (arr_way),
    .arr_index (arr_index),
    .tag_we    (tag_we),
    .tag_wr    (tag_wr),
    .tag_rd    (tag_rd),
    .data_we   (data_we),
    .data_wr   (data_wr),
    .data_rd   (data_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Tag/data arrays: synchronous write, combinational read of all ways.
  always @(posedge clk) begin
    if (tag_we)  tag_arr[arr_index][arr_way]  <= tag_wr;
    if (data_we) data_arr[arr_index][arr_way] <= data_wr;
  end

  always_comb begin
    for (int w = 0; w < 4; w++) begin
      tag_rd[w]  = tag_arr[arr_index][w];
      data_rd[w] = data_arr[arr_index][w];
    end
  end

  // Backing memory: acks on the third cycle of a request; ram[a] = a + 0x80 initially.
  initial begin
    int lat_cnt;
    lat_cnt   = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i + 8'h80);
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mem_ack = 1'b0;
        lat_cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req && !mem_hold) begin
        if (lat_cnt == 2) begin
          mem_ack   = 1'b1;
          mem_rdata = ram[mem_addr];
          if (mem_we) ram[mem_addr] = mem_wdata;
          lat_cnt   = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic sample();
    if (mem_req) begin
      n_mem++;
      o_mem_addr  = mem_addr;
      o_mem_we    = mem_we;
      o_mem_wdata = mem_wdata;
    end
    if (tag_we) begin
      n_tag++;
      o_tag_way = arr_way;
      o_tag_idx = arr_index;
      o_tag_val = tag_wr;
    end
    if (data_we) begin
      n_data++;
      o_data_way = arr_way;
      o_data_idx = arr_index;
      o_data_val = data_wr;
    end
    if (rsp_valid) begin
      got_rsp = 1'b1;
      o_rsp   = rsp_rdata;
    end
  endtask

  task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp_rdata);
    int cyc;
    exp_q.push_back(exp_rdata);
    n_mem = 0; n_tag = 0; n_data = 0; lat = 0; got_rsp = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    cyc = 0;
    while (cyc < 40) begin
      sample();
      if (got_rsp) break;
      @(negedge clk);
      lat++;
      cyc++;
    end
    if (got_rsp) check("rsp_rdata", o_rsp, exp_q.pop_front());
    else begin
      check("rsp_timeout", 0, 1);
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    check("rsp_pulse", rsp_valid, 0);
  endtask

  task automatic check_fill(input string nm, input int way, input int idx, input int tag,
                            input int data);
    check({nm, "_tag_we"}, n_tag, 1);
    check({nm, "_data_we"}, n_data, 1);
    check({nm, "_way"}, o_tag_way, way);
    check({nm, "_idx"}, o_tag_idx, idx);
    check({nm, "_tag"}, o_tag_val, tag);
    check({nm, "_data"}, o_data_val, data);
  endtask

  initial begin
    logic [7:0] fill_addr [5];
    int         fill_way  [5];
    int         cyc, n_rsp;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_hold = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_outputs", {rsp_valid, mem_req, mem_we, tag_we, data_we}, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    rst = 1'b0;

    // Cold read miss fills way 0 of set 1.
    do_req(1'b0, 8'h25, 8'h00, 8'hA5);
    check("t1_mem_seen", n_mem > 0, 1);
    check("t1_mem_addr", o_mem_addr, 8'h25);
    check("t1_mem_we", o_mem_we, 0);
    check_fill("t1", 0, 1, 6'h09, 8'hA5);

    do_req(1'b0, 8'h25, 8'h00, 8'hA5);
    check("t2_no_mem", n_mem, 0);
    check("t2_latency", lat, 2);
    check("t2_no_arr_wr", n_tag + n_data, 0);

    // Write hit: data array updated in place, memory written through.
    do_req(1'b1, 8'h25, 8'h3C, 8'h00);
    check("t3_data_we", n_data, 1);
    check("t3_data_way", o_data_way, 0);
    check("t3_data_idx", o_data_idx, 1);
    check("t3_data_val", o_data_val, 8'h3C);
    check("t3_tag_we", n_tag, 0);
    check("t3_mem_we", o_mem_we, 1);
    check("t3_mem_wdata", o_mem_wdata, 8'h3C);
    do_req(1'b0, 8'h25, 8'h00, 8'h3C);
    check("t3b_no_mem", n_mem, 0);
    check("t3b_latency", lat, 2);

    // Write miss.
    do_req(1'b1, 8'h40, 8'h77, 8'h00);
    check("t5_mem_we", o_mem_we, 1);
    check("t5_mem_addr", o_mem_addr, 8'h40);
`ifdef CACHE_CTRL_WRITE_ALLOC_EN
    check_fill("t5", 0, 0, 6'h10, 8'h77);
    do_req(1'b0, 8'h40, 8'h00, 8'h77);
    check("t5b_no_mem", n_mem, 0);
`else
    check("t5_tag_we", n_tag, 0);
    check("t5_data_we", n_data, 0);
    do_req(1'b0, 8'h40, 8'h00, 8'h77);
    check("t5b_mem_seen", n_mem > 0, 1);
`endif

    // Reset while the read miss waits on memory.
    mem_hold = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h29;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!mem_req && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_mem_req_seen", mem_req, 1);
    rst = 1'b1;
    #1;
    check("t6_mem_req_drop", mem_req, 0);
    check("t6_arr_we", {tag_we, data_we}, 0);
    check("t6_req_ready", req_ready, 0);
    n_rsp = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    rst = 1'b0;
    mem_hold = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    check("t6_no_rsp", n_rsp, 0);

    // Fill all four ways of set 1, then evict via the round-robin pointer.
    fill_addr = '{8'h01, 8'h05, 8'h09, 8'h0D, 8'h11};
    fill_way  = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, fill_addr[i], 8'h00, 8'(fill_addr[i] + 8'h80));
      check_fill($sformatf("t4_%0d", i), fill_way[i], 1, int'(fill_addr[i] >> 2),
                 int'(8'(fill_addr[i] + 8'h80)));
    end
    do_req(1'b0, 8'h05, 8'h00, 8'h85);
    check("t4_hit_no_mem", n_mem, 0);
    check("t4_hit_latency", lat, 2);
    do_req(1'b0, 8'h15, 8'h00, 8'h95);
    check_fill("t4_rr1", 1, 1, 6'h05, 8'h95);
    do_req(1'b0, 8'h01, 8'h00, 8'h81);
    check_fill("t4_rr2", 2, 1, 6'h00, 8'h81);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter WAYS, default 4: associativity, a power of two.
REQ-003 SHALL have parameter TOTAL_SIZE, default 16: total lines; sets = TOTAL_SIZE/WAYS.
REQ-004 SHALL have parameter RAM_DEPTH, default 256: backing memory words; AW = $clog2(RAM_DEPTH), IW = $clog2(TOTAL_SIZE/WAYS), TW = AW-IW.
REQ-005 SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid / req_ready, input / output, 1 bit each: CPU request handshake.
REQ-008 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have ports req_addr (AW bits) and req_wdata (WIDTH bits), both inputs: request address and write data.
REQ-010 SHALL have ports rsp_valid (1 bit) and rsp_rdata (WIDTH bits), both outputs: one-cycle completion pulse and read data.
REQ-011 SHALL have ports mem_req and mem_we (1 bit each), mem_addr (AW bits) and mem_wdata (WIDTH bits), all outputs: backing-memory request.
REQ-012 SHALL have ports mem_ack (1 bit) and mem_rdata (WIDTH bits), both inputs: memory completion and read data.
REQ-013 SHALL have ports arr_way (log2 WAYS bits) and arr_index (IW bits), both outputs: way and set select shared by the tag and data arrays.
REQ-014 SHALL have ports tag_we (1 bit) and tag_wr (TW bits) as outputs, and tag_rd (WAYS x TW, unpacked) as input: tag array port with combinational read.
REQ-015 SHALL have ports data_we (1 bit) and data_wr (WIDTH bits) as outputs, and data_rd (WAYS x WIDTH, unpacked) as input: data array port with combinational read.

Function
REQ-016 Address split SHALL be index = addr[IW-1:0] and tag = addr[AW-1:IW]; mem_addr SHALL always be the captured request address.
REQ-017 The FSM SHALL have states IDLE, LOOKUP, MEM_RD, MEM_WR and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, req_valid&&req_ready SHALL capture addr/we/wdata and go to LOOKUP; arr_index SHALL be driven from the captured index in all non-IDLE states.
REQ-019 In LOOKUP, hit SHALL mean valid[w][index] && tag_rd[w]==tag; if several ways match, the lowest-numbered way SHALL win.
REQ-020 A read hit SHALL register data_rd[hit way] into rsp_rdata and go to RESP, giving rsp_valid 2 cycles after acceptance.
REQ-021 A read miss SHALL go to MEM_RD; mem_req=1 and mem_we=0 SHALL be held until the mem_ack cycle.
REQ-022 On mem_ack in MEM_RD, the block SHALL assert tag_we and data_we at the victim way for one cycle, set its valid bit, update the victim pointer, register mem_rdata into rsp_rdata and go to RESP.
REQ-023 The victim SHALL be the lowest invalid way if one exists; otherwise it SHALL be rr[index], and rr[index] SHALL then increment modulo WAYS.
REQ-024 A write SHALL be write-through: on a write hit in LOOKUP, data_we SHALL pulse at the hit way with data_wr = wdata; the block SHALL then go to MEM_WR regardless of hit.
REQ-025 In MEM_WR, mem_req=1, mem_we=1 and mem_wdata = wdata SHALL be held until mem_ack, then the block SHALL go to RESP with rsp_rdata = 0.
REQ-026 In RESP, rsp_valid SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE; mem_ack outside MEM_RD/MEM_WR SHALL be ignored.
REQ-027 tag_we and data_we SHALL never assert outside the cycles named in REQ-022 and REQ-024.

Reset
REQ-028 While rst is high: state = IDLE, all valid bits = 0, all rr pointers = 0, req_ready = 0, and rsp_valid, rsp_rdata, mem_req, mem_we, tag_we and data_we all = 0.
REQ-029 Reset mid-transaction SHALL drop mem_req immediately, perform no array write and produce no rsp_valid for the aborted request.

Configuration
REQ-030 With CACHE_CTRL_WRITE_ALLOC_EN defined, a write miss SHALL on mem_ack write tag and data (wdata) at the victim way exactly as REQ-022 does, updating valid and rr; without it, a write miss SHALL leave all arrays and rr untouched.

Structure
REQ-031 Package cache_pkg SHALL hold the FSM state enum typedef and default-parameter constants; the victim selector (valid vector + rr in, way out) SHALL be sub-module cache_victim_sel.

Verification
REQ-032 Read addr 0x25 after reset -> mem_req with mem_addr=0x25; mem_rdata=0xA5 -> tag_we/data_we at way 0, index 1; rsp_rdata=0xA5.
REQ-033 Repeat read 0x25 -> no mem_req; rsp_valid 2 cycles after the handshake; rsp_rdata=0xA5.
REQ-034 Reads 0x01, 0x05, 0x09, 0x0D, 0x11 (all index 1) -> ways 0..3 filled in order, then 0x11 evicts way 0 and rr[1] becomes 1.
REQ-035 Write 0x25 with 0x3C after REQ-032 -> data_we at way 0, mem_we=1 with mem_wdata=0x3C; a following read of 0x25 returns 0x3C with no mem_req.
REQ-036 Write miss to 0x40 -> tag_we=0 without the macro and tag_we=1 with it; assert rst during MEM_RD -> mem_req=0 and no rsp_valid.
